// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator for the VGA path. It counts single-cycle pixel
//   strobes coming from the clock divider and presents, for every strobe,
//   the sync levels, the visible-area qualifier, the raw pixel coordinates
//   and end-of-line / end-of-frame markers. Everything runs on clk_in; the
//   slower pixel rate only ever arrives as the pix_en enable.
//
// Ports
//   clk_in    in   system clock, the only clock of the block
//   rst_n     in   synchronous reset, active-low
//   pix_en    in   pixel strobe, high for one clk_in cycle per pixel
//   hsync     out  horizontal sync, asserted level given by SYNC_POL
//   vsync     out  vertical sync, asserted level given by SYNC_POL
//   video_on  out  high while the presented pixel lies in the visible area
//   pixel_x   out  horizontal count of the presented pixel
//   pixel_y   out  vertical count of the presented pixel
//   line_end  out  one-cycle pulse on the last pixel of a line
//   frame_end out  one-cycle pulse on the last pixel of a frame
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          line_end,
    output logic          frame_end
);

    // Decode boundaries, sized to the counters so every compare is width-exact.
    localparam logic [XW-1:0] H_VIS_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);

    logic [XW-1:0] hCnt_q, hCnt_d;
    logic [YW-1:0] vCnt_q, vCnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          videoOn_q, videoOn_d;
    logic [XW-1:0] pixelX_q, pixelX_d;
    logic [YW-1:0] pixelY_q, pixelY_d;
    logic          lineEnd_q, lineEnd_d;
    logic          frameEnd_q, frameEnd_d;

    logic          hLast;
    logic          vLast;

    assign hLast = (hCnt_q == H_LAST);
    assign vLast = (vCnt_q == V_LAST);

    // Next-state logic. On a strobe the current counter position is decoded
    // into the output registers and the counters then step to the following
    // pixel, so the outputs always describe the pixel that was just counted.
    // Between strobes the presented pixel holds, but the end markers drop so
    // they stay one clk_in wide however sparse the strobes are.
    always_comb begin
        hCnt_d     = hCnt_q;
        vCnt_d     = vCnt_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        videoOn_d  = videoOn_q;
        pixelX_d   = pixelX_q;
        pixelY_d   = pixelY_q;
        lineEnd_d  = 1'b0;
        frameEnd_d = 1'b0;

        if (pix_en) begin
            hsync_d    = ((hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d    = ((vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
            videoOn_d  = (hCnt_q < H_VIS_END) && (vCnt_q < V_VIS_END);
            pixelX_d   = hCnt_q;
            pixelY_d   = vCnt_q;
            lineEnd_d  = hLast;
            frameEnd_d = hLast && vLast;

            if (hLast) begin
                hCnt_d = '0;
                vCnt_d = vLast ? '0 : vCnt_q + YW'(1);
            end else begin
                hCnt_d = hCnt_q + XW'(1);
            end
        end
    end

    // State and output registers. Reset is synchronous and takes priority
    // over a strobe arriving in the same cycle; syncs park at their idle level.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            hCnt_q     <= '0;
            vCnt_q     <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            videoOn_q  <= 1'b0;
            pixelX_q   <= '0;
            pixelY_q   <= '0;
            lineEnd_q  <= 1'b0;
            frameEnd_q <= 1'b0;
        end else begin
            hCnt_q     <= hCnt_d;
            vCnt_q     <= vCnt_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            videoOn_q  <= videoOn_d;
            pixelX_q   <= pixelX_d;
            pixelY_q   <= pixelY_d;
            lineEnd_q  <= lineEnd_d;
            frameEnd_q <= frameEnd_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = videoOn_q;
    assign pixel_x   = pixelX_q;
    assign pixel_y   = pixelY_q;
    assign line_end  = lineEnd_q;
    assign frame_end = frameEnd_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Bench for vga_sync_gen. One instance uses the standard 640x480 timing for
//   the line-level behaviour; a second, tiny raster (16 x 12, active-high
//   syncs) makes whole frames, strobe gaps and mid-frame reset affordable.
//   Expected outputs come from a behavioural raster model and travel through
//   a queue from the cycle that drives a strobe to the cycle that samples it.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic       le;
        logic       fe;
        logic [9:0] x;
        logic [9:0] y;
    } outT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-timing instance
    logic       rstN0 = 1'b0;
    logic       en0   = 1'b0;
    logic       hs0, vs0, von0, le0, fe0;
    logic [9:0] x0, y0;

    // Small-raster instance
    logic       rstN1 = 1'b0;
    logic       en1   = 1'b0;
    logic       hs1, vs1, von1, le1, fe1;
    logic [3:0] x1, y1;

    vga_sync_gen dutBig (
        .clk_in   (clk),
        .rst_n    (rstN0),
        .pix_en   (en0),
        .hsync    (hs0),
        .vsync    (vs0),
        .video_on (von0),
        .pixel_x  (x0),
        .pixel_y  (y0),
        .line_end (le0),
        .frame_end(fe0)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1)
    ) dutSmall (
        .clk_in   (clk),
        .rst_n    (rstN1),
        .pix_en   (en1),
        .hsync    (hs1),
        .vsync    (vs1),
        .video_on (von1),
        .pixel_x  (x1),
        .pixel_y  (y1),
        .line_end (le1),
        .frame_end(fe1)
    );

    // Raster geometry of both instances, indexed by instance select
    int hAct[2]  = '{640, 8};
    int hFp[2]   = '{16, 2};
    int hSyn[2]  = '{96, 3};
    int hTot[2]  = '{800, 16};
    int vAct[2]  = '{480, 6};
    int vFp[2]   = '{10, 2};
    int vSyn[2]  = '{2, 2};
    int vTot[2]  = '{525, 12};
    bit pol[2]   = '{1'b0, 1'b1};

    int  mh[2];
    int  mv[2];
    outT prevExp[2];
    outT expQ[$];
    outT lastObs;

    int total = 0;
    int bad   = 0;

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural view of what a strobe at raster position (h,v) must show
    function automatic outT modelOut(input int sel, input int h, input int v);
        outT o;
        int  hsB, vsB;
        hsB   = hAct[sel] + hFp[sel];
        vsB   = vAct[sel] + vFp[sel];
        o.hs  = (h >= hsB && h < hsB + hSyn[sel]) ? pol[sel] : ~pol[sel];
        o.vs  = (v >= vsB && v < vsB + vSyn[sel]) ? pol[sel] : ~pol[sel];
        o.von = (h < hAct[sel]) && (v < vAct[sel]);
        o.le  = (h == hTot[sel] - 1);
        o.fe  = (h == hTot[sel] - 1) && (v == vTot[sel] - 1);
        o.x   = 10'(h);
        o.y   = 10'(v);
        return o;
    endfunction

    function automatic outT getObs(input int sel);
        outT o;
        if (sel == 0) o = '{hs0, vs0, von0, le0, fe0, x0, y0};
        else          o = '{hs1, vs1, von1, le1, fe1, 10'(x1), 10'(y1)};
        return o;
    endfunction

    // One clk_in cycle on the selected instance: drive inputs, queue the
    // expected result, then sample one time unit after the edge and compare.
    task automatic applyStimulus(input int sel, input bit rstn, input bit en);
        outT e;
        if (sel == 0) begin rstN0 = rstn; en0 = en; end
        else          begin rstN1 = rstn; en1 = en; end
        if (!rstn) begin
            e      = '0;
            e.hs   = ~pol[sel];
            e.vs   = ~pol[sel];
            mh[sel] = 0;
            mv[sel] = 0;
        end else if (en) begin
            e = modelOut(sel, mh[sel], mv[sel]);
            if (mh[sel] == hTot[sel] - 1) begin
                mh[sel] = 0;
                mv[sel] = (mv[sel] == vTot[sel] - 1) ? 0 : mv[sel] + 1;
            end else begin
                mh[sel] = mh[sel] + 1;
            end
        end else begin
            e    = prevExp[sel];
            e.le = 1'b0;
            e.fe = 1'b0;
        end
        prevExp[sel] = e;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        lastObs = getObs(sel);
        e = expQ.pop_front();
        checkOutput((sel == 0) ? "big" : "small", 32'(lastObs), 32'(e));
    endtask

    initial begin
        int hsCount, hsFirst, hsLast, leCount, vsCount, feCount, feAt, gap;

        // Reset with strobes held high: reset must win
        for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b1);
        checkOutput("rstSyncs", {31'd0, lastObs.hs & lastObs.vs}, 32'd1);

        // Line 0 at half rate, tracking the hsync window and line_end
        hsCount = 0; hsFirst = -1; hsLast = -1; leCount = 0;
        for (int s = 0; s < 800; s++) begin
            applyStimulus(0, 1'b1, 1'b1);
            if (lastObs.hs == 1'b0) begin
                hsCount++;
                if (hsFirst < 0) hsFirst = s;
                hsLast = s;
            end
            if (lastObs.le) leCount++;
            if (s == 639) checkOutput("x639von", {21'd0, lastObs.von, lastObs.x}, {21'd0, 1'b1, 10'd639});
            if (s == 640) checkOutput("x640von", {21'd0, lastObs.von, lastObs.x}, {21'd0, 1'b0, 10'd640});
            applyStimulus(0, 1'b1, 1'b0);
            if (lastObs.le) leCount++;
        end
        checkOutput("hsWidth", 32'(hsCount), 32'd96);
        checkOutput("hsFirst", 32'(hsFirst), 32'd656);
        checkOutput("hsLast", 32'(hsLast), 32'd751);
        checkOutput("leCount", 32'(leCount), 32'd1);
        applyStimulus(0, 1'b1, 1'b1);
        checkOutput("line1Start", {12'd0, lastObs.x, lastObs.y}, {12'd0, 10'd0, 10'd1});

        // Small raster: full frame with continuous strobes
        for (int i = 0; i < 3; i++) applyStimulus(1, 1'b0, 1'b1);
        vsCount = 0; feCount = 0; feAt = -1;
        for (int s = 0; s < 192; s++) begin
            applyStimulus(1, 1'b1, 1'b1);
            if (lastObs.vs == 1'b1) vsCount++;
            if (lastObs.fe) begin feCount++; feAt = s; end
        end
        checkOutput("vsCycles", 32'(vsCount), 32'd32);
        checkOutput("feCount", 32'(feCount), 32'd1);
        checkOutput("feAt", 32'(feAt), 32'd191);
        applyStimulus(1, 1'b1, 1'b1);
        checkOutput("wrap", {11'd0, lastObs.von, lastObs.x, lastObs.y}, {11'd0, 1'b1, 20'd0});

        // Same frame again with random gaps between strobes
        feCount = 0;
        for (int s = 0; s < 191; s++) begin
            gap = $urandom_range(0, 7);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1, 1'b1, 1'b0);
                if (lastObs.fe) feCount++;
            end
            applyStimulus(1, 1'b1, 1'b1);
            if (lastObs.fe) feCount++;
        end
        checkOutput("gapFeCount", 32'(feCount), 32'd1);

        // Walk into the frame and reset mid-frame at (5,7)
        for (int s = 0; s < 118; s++) applyStimulus(1, 1'b1, 1'b1);
        checkOutput("preRstPos", {12'd0, lastObs.x, lastObs.y}, {12'd0, 10'd5, 10'd7});
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b1);
        checkOutput("postRst", {11'd0, lastObs.von, lastObs.x, lastObs.y}, {11'd0, 1'b1, 20'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
